tapped_line_buffer: RTL and testbench
=====================================

# tapped_line_buffer

Multi-line video delay buffer. Each line is held in its own circular line memory. Every accepted pixel produces a registered vertical column of taps: the current pixel plus the pixels directly above it in the previous NUMBER_OF_LINES lines. It sits between the camera/pixel pipeline and the paddle-localization window filters (e.g. 3x3 erosion/dilation), which need the taps, per-tap validity and the current column.

## Interface
- NUMBER_OF_LINES, 2, number of delayed lines (taps 1..NUMBER_OF_LINES); must be >= 1
- WIDTH, 640, pixels per line; must be >= 2
- BUS_SIZE, 25, bits per pixel
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- EN  input  1  pixel accept strobe; data is sampled on a rising edge where EN=1
- sof  input  1  start-of-frame; clears column and line counters (memory contents kept)
- data  input  BUS_SIZE  input pixel
- taps  output  (NUMBER_OF_LINES+1)*BUS_SIZE  tap k at bits [k*BUS_SIZE +: BUS_SIZE]; tap 0 = current pixel
- tap_valid  output  NUMBER_OF_LINES+1  bit k set when tap k holds a real sample of the current frame; bit 0 always 1 when out_valid
- out_valid  output  1  one-cycle pulse, taps updated
- col  output  $clog2(WIDTH)  column index of the pixel in tap 0

## Operation
- Samples s_0, s_1, … are numbered from the last reset or sof.
- The edge accepting s_i loads tap k with s_{i-k*WIDTH} for k = 0..NUMBER_OF_LINES. That is, the pixel in the same column, k lines earlier.
- Storage: NUMBER_OF_LINES memories of WIDTH words, addressed by the write column wcol.
  - On accept, memory 1 reads its old word at wcol and writes data.
  - Memory k+1 writes the old word read from memory k.
  - Read-old-data semantics are required within the same cycle.
- wcol counts 0..WIDTH-1 and wraps to 0. line_count increments on each wrap and saturates at NUMBER_OF_LINES.
- tap_valid[k] is set for k <= line_count, evaluated before the current accept's wrap. In other words, line_count as it was when s_i arrived.
- col is registered with tap 0 and equals i mod WIDTH.
- EN=0: no memory write, no counter change; taps, col and tap_valid hold; out_valid=0.
- sof=1 at an edge:
  - wcol and line_count are cleared.
  - If EN=1 at the same edge, that sample is s_0: col=0, tap_valid=…001, and memory is written at column 0.
  - If EN=0, no sample is accepted.
- reset=1: overrides EN and sof.
  - wcol=0, line_count=0, taps=0, tap_valid=0, out_valid=0, col=0.
  - Memory is not cleared.
- Reset mid-line: the next accepted sample after reset is s_0 at column 0. Stale memory is masked by tap_valid.

## Timing
- Latency: the sample accepted at edge n appears on taps[0] and the other outputs after edge n (one clock).
- Throughput: one pixel per clock with EN held high; gaps in EN are allowed anywhere, including mid-line.
- out_valid: high exactly the cycle after each accepting edge; registered.
- Tap k first becomes valid at sample s_{k*WIDTH}, and stays valid until the next reset or sof.
- Wrap: the accept at wcol=WIDTH-1 produces col=WIDTH-1. The next accept produces col=0 and increments line_count.
- No combinational path from inputs to outputs.

## Configuration
- LINE_BUFFER_ZERO_FILL_EN defined:
  - Any tap whose tap_valid bit is 0 is driven to all-zeros in the registered output.
  - Used for zero-padded borders.
- LINE_BUFFER_ZERO_FILL_EN undefined:
  - Invalid taps carry whatever the memory returned (stale or uninitialised).
  - Consumers must use tap_valid.
- The macro does not affect tap 0, tap_valid, col, out_valid or latency.

## Test plan
- Use NUMBER_OF_LINES=2, WIDTH=4, BUS_SIZE=8.
- Reset then fill: reset, then EN=1 with data=i for i=0..11.
  - At accept of s_9: taps = {1,5,9}, col=1, tap_valid=3'b111.
  - At s_5: tap_valid=3'b011, tap1=1.
- EN gaps: same stream with EN low every other cycle.
  - Tap values identical to the previous case, per sample.
  - out_valid low on the cycle after each EN=0 edge; outputs hold.
- Wrap/saturation: stream 20 samples.
  - col sequence 0,1,2,3,0,…
  - tap_valid stays 3'b111 from s_8 onward.
  - s_19 gives taps {11,15,19}.
- sof mid-line: after s_6, assert sof with EN=1 and data=0xAA.
  - col=0, tap_valid=3'b001, tap0=0xAA.
  - Four samples later, tap1=0xAA.
- Reset priority: reset=1 with EN=1 and sof=1.
  - All outputs 0; no memory write (verify: the next frame's tap1 at s_4 equals s_0, not 0xAA).
- Zero fill: with LINE_BUFFER_ZERO_FILL_EN defined, second frame s_1.
  - taps[1] and taps[2] = 0.
  - Without the macro they equal the previous frame's column-1 data.

Source files
------------

// File: rtl/tapped_line_buffer_if.sv
// Pixel-stream bundle for tapped_line_buffer: the accept/sof/data inputs and the tap column
// outputs. The producer drives through master; the line buffer sits on slave.
interface tapped_line_buffer_if #(
   parameter int unsigned NUMBER_OF_LINES = 2,
   parameter int unsigned WIDTH           = 640,
   parameter int unsigned BUS_SIZE        = 25
);
   localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic                                     EN;
   logic                                     sof;
   logic [BUS_SIZE-1:0]                      data;
   logic [(NUMBER_OF_LINES+1)*BUS_SIZE-1:0]  taps;
   logic [NUMBER_OF_LINES:0]                 tap_valid;
   logic                                     out_valid;
   logic [COL_W-1:0]                         col;

   modport master (
      output EN, sof, data,
      input  taps, tap_valid, out_valid, col
   );

   modport slave (
      input  EN, sof, data,
      output taps, tap_valid, out_valid, col
   );
endinterface

// File: rtl/tapped_line_buffer.sv
// Multi-line video delay buffer: cascaded circular line memories yield a registered vertical
// column of taps per accepted pixel. Build option LINE_BUFFER_ZERO_FILL_EN zeroes invalid taps.
module tapped_line_buffer #(
   parameter int unsigned NUMBER_OF_LINES = 2,
   parameter int unsigned WIDTH           = 640,
   parameter int unsigned BUS_SIZE        = 25
) (
   input  logic                  clock,
   input  logic                  reset,
   tapped_line_buffer_if.slave   bus
);

   localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned LC_W  = $clog2(NUMBER_OF_LINES + 1);

   typedef logic [BUS_SIZE-1:0] pixel_t;

   // Line memories; no reset so they map onto RAM.
   pixel_t mem [NUMBER_OF_LINES][WIDTH];

   pixel_t                   rd       [NUMBER_OF_LINES];
   pixel_t                   taps_d   [NUMBER_OF_LINES+1];
   pixel_t                   taps_q   [NUMBER_OF_LINES+1];
   logic [COL_W-1:0]         wcol_q, wcol_d, wcol_eff;
   logic [LC_W-1:0]          line_q, line_d, line_eff;
   logic [NUMBER_OF_LINES:0] valid_d, valid_q;
   logic [COL_W-1:0]         col_q;
   logic                     out_valid_q;
   logic                     wrap;

   // sof restarts the frame at this same edge, so the accepted sample (if any) is s_0.
   always_comb begin
      wcol_eff = bus.sof ? '0 : wcol_q;
      line_eff = bus.sof ? '0 : line_q;
      wrap     = (wcol_eff == COL_W'(WIDTH - 1));
      wcol_d   = wcol_eff;
      line_d   = line_eff;
      if (bus.EN) begin
         wcol_d = wrap ? '0 : wcol_eff + 1'b1;
         if (wrap && (line_eff != LC_W'(NUMBER_OF_LINES))) begin
            line_d = line_eff + 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUMBER_OF_LINES; k++) begin
         rd[k] = mem[k][wcol_eff];
      end
      for (int k = 0; k <= NUMBER_OF_LINES; k++) begin
         valid_d[k] = (LC_W'(k) <= line_eff);
      end
      taps_d[0] = bus.data;
      for (int k = 1; k <= NUMBER_OF_LINES; k++) begin
`ifdef LINE_BUFFER_ZERO_FILL_EN
         taps_d[k] = valid_d[k] ? rd[k-1] : '0;
`else
         taps_d[k] = rd[k-1];
`endif
      end
   end

   // Each memory pushes its old word into the next one: read-old-data within the cycle.
   always_ff @(posedge clock) begin
      if (!reset && bus.EN) begin
         mem[0][wcol_eff] <= bus.data;
         for (int k = 1; k < NUMBER_OF_LINES; k++) begin
            mem[k][wcol_eff] <= rd[k-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wcol_q      <= '0;
         line_q      <= '0;
         valid_q     <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k <= NUMBER_OF_LINES; k++) begin
            taps_q[k] <= '0;
         end
      end else begin
         wcol_q      <= wcol_d;
         line_q      <= line_d;
         out_valid_q <= bus.EN;
         if (bus.EN) begin
            valid_q <= valid_d;
            col_q   <= wcol_eff;
            for (int k = 0; k <= NUMBER_OF_LINES; k++) begin
               taps_q[k] <= taps_d[k];
            end
         end
      end
   end

   for (genvar g = 0; g <= NUMBER_OF_LINES; g++) begin : g_taps
      assign bus.taps[g*BUS_SIZE +: BUS_SIZE] = taps_q[g];
   end

   assign bus.tap_valid = valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.col       = col_q;

endmodule

// File: tb/tb_tapped_line_buffer.sv
// Self-checking bench for tapped_line_buffer (2 lines, width 4, 8-bit pixels): directed table,
// hand sequences and random traffic against a per-column history model.
module tb_tapped_line_buffer;
   localparam int unsigned N = 2;
   localparam int unsigned W = 4;
   localparam int unsigned B = 8;
`ifdef LINE_BUFFER_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tapped_line_buffer_if #(.NUMBER_OF_LINES(N), .WIDTH(W), .BUS_SIZE(B)) lb ();

   tapped_line_buffer #(.NUMBER_OF_LINES(N), .WIDTH(W), .BUS_SIZE(B)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (lb)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: every sample ever written at a column, oldest first; memory is never cleared.
   logic [7:0] hist [W][$];
   int         m_col, m_line;
   logic [7:0] e_taps  [N+1];
   bit         e_known [N+1];
   logic [2:0] e_tv;
   logic [1:0] e_col;
   logic       e_ov;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] tap(input int k);
      return lb.taps[k*B +: B];
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit sof, input logic [7:0] d);
      int sz;
      if (rst) begin
         m_col = 0; m_line = 0; e_tv = '0; e_col = '0; e_ov = 1'b0;
         for (int k = 0; k <= N; k++) begin e_taps[k] = '0; e_known[k] = 1'b1; end
         return;
      end
      if (sof) begin m_col = 0; m_line = 0; end
      e_ov = en;
      if (!en) return;
      e_col = 2'(m_col);
      for (int k = 0; k <= N; k++) e_tv[k] = (k <= m_line);
      e_taps[0] = d; e_known[0] = 1'b1;
      sz = hist[m_col].size();
      for (int k = 1; k <= N; k++) begin
         if (ZF && !e_tv[k]) begin e_taps[k] = '0; e_known[k] = 1'b1; end
         else if (sz >= k) begin e_taps[k] = hist[m_col][sz-k]; e_known[k] = 1'b1; end
         else e_known[k] = 1'b0;
      end
      hist[m_col].push_back(d);
      m_col++;
      if (m_col == W) begin
         m_col = 0;
         if (m_line < N) m_line++;
      end
   endtask

   task automatic cycle(input bit rst, input bit en, input bit sof, input logic [7:0] d);
      reset = rst; lb.EN = en; lb.sof = sof; lb.data = d;
      @(posedge clock);
      #1;
      model_step(rst, en, sof, d);
      chk("out_valid", 32'(lb.out_valid), 32'(e_ov));
      chk("col", 32'(lb.col), 32'(e_col));
      chk("tap_valid", 32'(lb.tap_valid), 32'(e_tv));
      for (int k = 0; k <= N; k++) begin
         if (e_known[k]) chk($sformatf("model tap%0d", k), 32'(tap(k)), 32'(e_taps[k]));
      end
   endtask

   typedef struct {
      bit         rst, en, sof;
      logic [7:0] data;
      logic [7:0] t2, t1, t0;
      logic [2:0] tv;
      logic [1:0] col;
      bit         ov;
   } vec_t;

   vec_t vecs [13];

   initial begin
      lb.EN = 1'b0; lb.sof = 1'b0; lb.data = '0;

      // Reset then fill 12 samples; invalid taps are 0 here and only compared under zero fill.
      vecs[0]  = '{1, 0, 0, 8'h00, 8'd0, 8'd0, 8'd0,  3'b000, 2'd0, 0};
      vecs[1]  = '{0, 1, 0, 8'd0,  8'd0, 8'd0, 8'd0,  3'b001, 2'd0, 1};
      vecs[2]  = '{0, 1, 0, 8'd1,  8'd0, 8'd0, 8'd1,  3'b001, 2'd1, 1};
      vecs[3]  = '{0, 1, 0, 8'd2,  8'd0, 8'd0, 8'd2,  3'b001, 2'd2, 1};
      vecs[4]  = '{0, 1, 0, 8'd3,  8'd0, 8'd0, 8'd3,  3'b001, 2'd3, 1};
      vecs[5]  = '{0, 1, 0, 8'd4,  8'd0, 8'd0, 8'd4,  3'b011, 2'd0, 1};
      vecs[6]  = '{0, 1, 0, 8'd5,  8'd0, 8'd1, 8'd5,  3'b011, 2'd1, 1};
      vecs[7]  = '{0, 1, 0, 8'd6,  8'd0, 8'd2, 8'd6,  3'b011, 2'd2, 1};
      vecs[8]  = '{0, 1, 0, 8'd7,  8'd0, 8'd3, 8'd7,  3'b011, 2'd3, 1};
      vecs[9]  = '{0, 1, 0, 8'd8,  8'd0, 8'd4, 8'd8,  3'b111, 2'd0, 1};
      vecs[10] = '{0, 1, 0, 8'd9,  8'd1, 8'd5, 8'd9,  3'b111, 2'd1, 1};
      vecs[11] = '{0, 1, 0, 8'd10, 8'd2, 8'd6, 8'd10, 3'b111, 2'd2, 1};
      vecs[12] = '{0, 1, 0, 8'd11, 8'd3, 8'd7, 8'd11, 3'b111, 2'd3, 1};

      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].sof, vecs[i].data);
         chk($sformatf("vec%0d out_valid", i), 32'(lb.out_valid), 32'(vecs[i].ov));
         chk($sformatf("vec%0d col", i), 32'(lb.col), 32'(vecs[i].col));
         chk($sformatf("vec%0d tap_valid", i), 32'(lb.tap_valid), 32'(vecs[i].tv));
         chk($sformatf("vec%0d tap0", i), 32'(tap(0)), 32'(vecs[i].t0));
         if (ZF || vecs[i].tv[1]) chk($sformatf("vec%0d tap1", i), 32'(tap(1)), 32'(vecs[i].t1));
         if (ZF || vecs[i].tv[2]) chk($sformatf("vec%0d tap2", i), 32'(tap(2)), 32'(vecs[i].t2));
      end

      // Same stream with EN low every other cycle.
      cycle(1, 0, 0, 8'h00);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 0, 8'(i));
         if (i == 9) chk("gap s9 taps", 32'(lb.taps), 32'h010509);
         cycle(0, 0, 0, 8'hEE);
         if (i == 9) chk("gap s9 hold", 32'(lb.taps), 32'h010509);
      end

      // Wrap and saturation over 20 samples.
      cycle(1, 0, 0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         cycle(0, 1, 0, 8'(i));
         if (i == 19) chk("wrap s19 taps", 32'(lb.taps), 32'h0B0F13);
      end

      // sof mid-line after s_6.
      cycle(1, 0, 0, 8'h00);
      for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'(i));
      cycle(0, 1, 1, 8'hAA);
      chk("sof col", 32'(lb.col), 32'd0);
      chk("sof tap_valid", 32'(lb.tap_valid), 32'b001);
      chk("sof tap0", 32'(tap(0)), 32'hAA);
      for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 8'(8'h20 + i));
      chk("sof+4 tap1", 32'(tap(1)), 32'hAA);

      // Reset beats EN and sof and writes nothing.
      cycle(1, 1, 1, 8'hAA);
      chk("rst taps", 32'(lb.taps), 32'h0);
      chk("rst tap_valid", 32'(lb.tap_valid), 32'h0);
      chk("rst out_valid", 32'(lb.out_valid), 32'h0);
      for (int i = 0; i < 9; i++) begin
         cycle(0, 1, 0, 8'(8'h40 + i));
         if (i == 4) chk("rst s4 tap1", 32'(tap(1)), 32'h40);
      end

      // Second frame s_1: stale column-1 data, or zeros with zero fill.
      cycle(0, 1, 1, 8'h50);
      for (int i = 1; i < 12; i++) cycle(0, 1, 0, 8'(8'h50 + i));
      cycle(0, 1, 1, 8'h60);
      cycle(0, 1, 0, 8'h61);
      chk("frame2 s1 tap1", 32'(tap(1)), ZF ? 32'h0 : 32'h59);
      chk("frame2 s1 tap2", 32'(tap(2)), ZF ? 32'h0 : 32'h55);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
               $urandom_range(0, 49) == 0, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
